// File: rtl/dht22_responder.sv
// DHT22 sensor-side emulator: detects the host start pulse, sends the ACK,
// then a 40-bit humidity/temperature/checksum frame on an open-drain bus.
module dht22_responder #(
  parameter int unsigned START_MIN  = 50000,
  parameter int unsigned RESP_DELAY = 3000,
  parameter int unsigned ACK_LOW    = 8000,
  parameter int unsigned ACK_HIGH   = 8000,
  parameter int unsigned BIT_LOW    = 5000,
  parameter int unsigned ZERO_HIGH  = 2700,
  parameter int unsigned ONE_HIGH   = 7000
) (
  input  logic        CLK100MHZ,
  input  logic        CPU_RESETN,
  input  logic        bus_in,
  output logic        bus_drive_low,
  input  logic [15:0] humidity,
  input  logic [15:0] temperature,
  output logic        busy,
  output logic        frame_done
);

  localparam logic [19:0] C_START = 20'(START_MIN);
  localparam logic [19:0] C_RESP  = 20'(RESP_DELAY);
  localparam logic [19:0] C_ACKL  = 20'(ACK_LOW);
  localparam logic [19:0] C_ACKH  = 20'(ACK_HIGH);
  localparam logic [19:0] C_BITL  = 20'(BIT_LOW);
  localparam logic [19:0] C_ZERO  = 20'(ZERO_HIGH);
  localparam logic [19:0] C_ONE   = 20'(ONE_HIGH);

  typedef enum logic [3:0] {
    S_IDLE, S_START_LOW, S_WAIT_REL, S_RESP_DELAY,
    S_ACK_LO, S_ACK_HI, S_BIT_LO, S_BIT_HI, S_END_LO
  } state_t;

  state_t      state, state_nx;
  logic        sync1, s;
  logic [19:0] cnt, cnt_nx, hi_len;
  logic [5:0]  idx, idx_nx;
  logic [39:0] sr, sr_nx;
  logic [7:0]  checksum;
  logic        drive_nx, busy_nx, done_nx;

  // Idle bus is pulled up, so the synchronizer resets to the released level.
  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      sync1 <= 1'b1;
      s     <= 1'b1;
    end else begin
      sync1 <= bus_in;
      s     <= sync1;
    end
  end

  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      state         <= S_IDLE;
      cnt           <= '0;
      idx           <= '0;
      sr            <= '0;
      bus_drive_low <= 1'b0;
      busy          <= 1'b0;
      frame_done    <= 1'b0;
    end else begin
      state         <= state_nx;
      cnt           <= cnt_nx;
      idx           <= idx_nx;
      sr            <= sr_nx;
      bus_drive_low <= drive_nx;
      busy          <= busy_nx;
      frame_done    <= done_nx;
    end
  end

  assign checksum = humidity[15:8] + humidity[7:0] + temperature[15:8] + temperature[7:0];
  assign hi_len   = sr[39] ? C_ONE : C_ZERO;

  // Timed phases enter with cnt = 1 and leave on the cycle cnt hits the length.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    idx_nx   = idx;
    sr_nx    = sr;
    busy_nx  = busy;
    done_nx  = 1'b0;
    case (state)
      S_IDLE: begin
        busy_nx = 1'b0;
        if (!s) begin
          state_nx = S_START_LOW;
          cnt_nx   = 20'd1;
        end
      end
      S_START_LOW: begin
        if (s) begin
          state_nx = S_IDLE;
          cnt_nx   = '0;
        end else if (cnt + 20'd1 >= C_START) begin
          state_nx = S_WAIT_REL;
          cnt_nx   = '0;
          busy_nx  = 1'b1;
        end else begin
          cnt_nx = cnt + 20'd1;
        end
      end
      S_WAIT_REL: begin
        if (s) begin
          sr_nx    = {humidity, temperature, checksum};
          idx_nx   = '0;
          cnt_nx   = 20'd1;
          state_nx = S_RESP_DELAY;
        end
      end
      S_RESP_DELAY: begin
        if (!s) begin
          state_nx = S_START_LOW;
          cnt_nx   = 20'd1;
          busy_nx  = 1'b0;
        end else if (cnt == C_RESP) begin
          state_nx = S_ACK_LO;
          cnt_nx   = 20'd1;
        end else begin
          cnt_nx = cnt + 20'd1;
        end
      end
      S_ACK_LO: begin
        if (cnt == C_ACKL) begin
          state_nx = S_ACK_HI;
          cnt_nx   = 20'd1;
        end else begin
          cnt_nx = cnt + 20'd1;
        end
      end
      S_ACK_HI: begin
        if (cnt == C_ACKH) begin
          state_nx = S_BIT_LO;
          cnt_nx   = 20'd1;
        end else begin
          cnt_nx = cnt + 20'd1;
        end
      end
      S_BIT_LO: begin
        if (cnt == C_BITL) begin
          state_nx = S_BIT_HI;
          cnt_nx   = 20'd1;
        end else begin
          cnt_nx = cnt + 20'd1;
        end
      end
      S_BIT_HI: begin
        if (cnt == hi_len) begin
          sr_nx    = {sr[38:0], 1'b0};
          idx_nx   = idx + 6'd1;
          cnt_nx   = 20'd1;
          state_nx = (idx + 6'd1 == 6'd40) ? S_END_LO : S_BIT_LO;
        end else begin
          cnt_nx = cnt + 20'd1;
        end
      end
      S_END_LO: begin
        if (cnt == C_BITL) begin
          state_nx = S_IDLE;
          cnt_nx   = '0;
          busy_nx  = 1'b0;
          done_nx  = 1'b1;
        end else begin
          cnt_nx = cnt + 20'd1;
        end
      end
      default: begin
        state_nx = S_IDLE;
        cnt_nx   = '0;
        busy_nx  = 1'b0;
      end
    endcase
    drive_nx = (state_nx == S_ACK_LO) || (state_nx == S_BIT_LO) || (state_nx == S_END_LO);
  end

endmodule

// File: tb/tb_dht22_responder.sv
// Self-checking bench for dht22_responder with shortened phase lengths;
// frames are captured as run lengths on the bus and decoded back to bytes.
module tb_dht22_responder;

  localparam int unsigned SMIN = 20;
  localparam int unsigned RD   = 12;
  localparam int unsigned ACKL = 8;
  localparam int unsigned ACKH = 9;
  localparam int unsigned BITL = 5;
  localparam int unsigned ZH   = 3;
  localparam int unsigned OH   = 7;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        bus_in = 1'b1;
  logic        bus_drive_low;
  logic [15:0] humidity = '0;
  logic [15:0] temperature = '0;
  logic        busy;
  logic        frame_done;

  int unsigned n_checks = 0;
  int unsigned n_pass = 0;

  dht22_responder #(
    .START_MIN (SMIN),
    .RESP_DELAY(RD),
    .ACK_LOW   (ACKL),
    .ACK_HIGH  (ACKH),
    .BIT_LOW   (BITL),
    .ZERO_HIGH (ZH),
    .ONE_HIGH  (OH)
  ) dut (
    .CLK100MHZ    (clk),
    .CPU_RESETN   (rst_n),
    .bus_in       (bus_in),
    .bus_drive_low(bus_drive_low),
    .humidity     (humidity),
    .temperature  (temperature),
    .busy         (busy),
    .frame_done   (frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned low_len;
    bit          qualifies;
  } start_vec_t;

  typedef struct {
    logic [15:0] h;
    logic [15:0] t;
    logic [39:0] exp;
    bit          chg;
  } frame_vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, req);
  endtask

  function automatic logic [39:0] model_frame(input logic [15:0] h, input logic [15:0] t);
    logic [7:0] cs;
    cs = h[15:8] + h[7:0] + t[15:8] + t[7:0];
    return {h, t, cs};
  endfunction

  // Call at posedge+1; returns at posedge+1 with bus_in just released.
  task automatic do_start(input int unsigned len, output bit saw_drive, output bit saw_busy);
    saw_drive = 1'b0;
    saw_busy  = 1'b0;
    bus_in = 1'b0;
    repeat (len) begin
      @(posedge clk); #1;
      if (bus_drive_low) saw_drive = 1'b1;
      if (busy) saw_busy = 1'b1;
    end
    bus_in = 1'b1;
  endtask

  task automatic idle_cycles(input int unsigned n, output bit saw_drive, output bit saw_busy,
                             output bit saw_done);
    saw_drive = 1'b0;
    saw_busy  = 1'b0;
    saw_done  = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
      if (bus_drive_low) saw_drive = 1'b1;
      if (busy) saw_busy = 1'b1;
      if (frame_done) saw_done = 1'b1;
    end
  endtask

  // Expected wire: ACK low/high, 40 x (BITL low, ZH/OH high), BITL end low.
  task automatic run_frame(input logic [39:0] exp, input bit chg, input string tag);
    int unsigned k, cur, cyc, mism, ri;
    int unsigned runs[$];
    int unsigned want[$];
    bit level, done, busy_bad;
    logic [39:0] dec;
    k = 0;
    do begin
      @(posedge clk); #1;
      k++;
    end while (!bus_drive_low && k < 3 + RD + 40);
    check({tag, " ack_start"}, 64'(k), 64'(3 + RD));
    if (!bus_drive_low) return;
    cur = 1; level = 1'b1; done = 1'b0; busy_bad = !busy; cyc = 0;
    while (!done && cyc < 4000) begin
      @(posedge clk); #1;
      cyc++;
      if (frame_done) begin
        runs.push_back(cur);
        done = 1'b1;
        if (busy) busy_bad = 1'b1;
      end else begin
        if (!busy) busy_bad = 1'b1;
        if (bus_drive_low == level) cur++;
        else begin
          runs.push_back(cur);
          level = bus_drive_low;
          cur = 1;
          if (chg && runs.size() == 1) humidity = 16'h1234;
        end
      end
    end
    check({tag, " frame_done_seen"}, 64'(done), 64'd1);
    if (!done) return;
    check({tag, " released_at_done"}, 64'(bus_drive_low), 64'd0);
    want.push_back(ACKL);
    want.push_back(ACKH);
    for (int b = 39; b >= 0; b--) begin
      want.push_back(BITL);
      want.push_back(exp[b] ? OH : ZH);
    end
    want.push_back(BITL);
    mism = 0;
    if (runs.size() != want.size()) mism = 1000 + runs.size();
    else for (int i = 0; i < want.size(); i++) if (runs[i] != want[i]) mism++;
    check({tag, " run_mismatches"}, 64'(mism), 64'd0);
    dec = '0;
    for (int b = 0; b < 40; b++) begin
      ri = 3 + 2 * b;
      if (ri < runs.size()) dec[39 - b] = (runs[ri] == OH);
    end
    check({tag, " decoded_bytes"}, 64'(dec), 64'(exp));
    check({tag, " busy_window_bad"}, 64'(busy_bad), 64'd0);
    @(posedge clk); #1;
    check({tag, " done_pulse_busy"}, 64'({frame_done, busy}), 64'd0);
  endtask

  start_vec_t sv[4];
  frame_vec_t fv[5];

  initial begin
    bit sd, sb, sdn;
    int unsigned rises, cyc;
    bit prev;
    logic [15:0] rh, rt;

    sv[0] = '{3, 1'b0};
    sv[1] = '{SMIN - 1, 1'b0};
    sv[2] = '{SMIN, 1'b1};
    sv[3] = '{SMIN * 3, 1'b1};

    fv[0] = '{16'h028C, 16'h015F, 40'h028C015FEE, 1'b0};
    fv[1] = '{16'hFFFF, 16'hFFFF, 40'hFFFFFFFFFC, 1'b0};
    fv[2] = '{16'h0000, 16'h0000, 40'h0000000000, 1'b0};
    fv[3] = '{16'h028C, 16'h015F, 40'h028C015FEE, 1'b1};
    fv[4] = '{16'h0000, 16'h8065, 40'h00008065E5, 1'b0};

    #3;
    check("reset drive", 64'(bus_drive_low), 64'd0);
    check("reset busy", 64'(busy), 64'd0);
    check("reset done", 64'(frame_done), 64'd0);
    #20 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    for (int i = 0; i < 4; i++) begin
      humidity = 16'h0123; temperature = 16'h0456;
      do_start(sv[i].low_len, sd, sb);
      if (sv[i].qualifies) begin
        run_frame(model_frame(16'h0123, 16'h0456), 1'b0, $sformatf("start%0d", i));
      end else begin
        idle_cycles(3 + RD + ACKL + 10, sd, sb, sdn);
        check($sformatf("start%0d rejected_activity", i), 64'({sd, sb, sdn}), 64'd0);
      end
      idle_cycles(5, sd, sb, sdn);
    end

    for (int i = 0; i < 5; i++) begin
      humidity = fv[i].h; temperature = fv[i].t;
      do_start(SMIN + 5, sd, sb);
      run_frame(fv[i].exp, fv[i].chg, $sformatf("frame%0d", i));
      idle_cycles(5, sd, sb, sdn);
    end

    // Host restarts while the responder is in its post-release delay.
    humidity = 16'h0A0B; temperature = 16'h0C0D;
    do_start(SMIN + 5, sd, sb);
    idle_cycles(4, sd, sb, sdn);
    do_start(SMIN + 10, prev, sb);
    check("restart no_first_ack", 64'({sd, prev, sdn}), 64'd0);
    run_frame(model_frame(16'h0A0B, 16'h0C0D), 1'b0, "restart");
    idle_cycles(3 * (ACKL + ACKH + 41 * BITL), sd, sb, sdn);
    check("restart single_frame", 64'({sd, sb, sdn}), 64'd0);

    // Reset during bit 17's low phase (ACK is rise 1, bit b low is rise b+2).
    humidity = 16'hBEEF; temperature = 16'h8001;
    do_start(SMIN + 5, sd, sb);
    rises = 0; prev = 1'b0; cyc = 0;
    while (rises < 19 && cyc < 3000) begin
      @(posedge clk); #1;
      cyc++;
      if (bus_drive_low && !prev) rises++;
      prev = bus_drive_low;
    end
    check("reset_mid reached_bit17", 64'(rises), 64'd19);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("reset_mid pre_drive", 64'(bus_drive_low), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("reset_mid immediate", 64'({bus_drive_low, busy}), 64'd0);
    idle_cycles(4, sd, sb, sdn);
    check("reset_mid held", 64'({sd, sb, sdn}), 64'd0);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    idle_cycles(3, sd, sb, sdn);
    check("reset_mid no_done_after", 64'({sd, sb, sdn}), 64'd0);
    humidity = 16'h0321; temperature = 16'hFF9C;
    do_start(SMIN + 2, sd, sb);
    run_frame(model_frame(16'h0321, 16'hFF9C), 1'b0, "after_reset");

    for (int i = 0; i < 4; i++) begin
      rh = 16'($urandom);
      rt = 16'($urandom);
      humidity = rh; temperature = rt;
      do_start(SMIN + $urandom_range(0, 30), sd, sb);
      run_frame(model_frame(rh, rt), 1'b0, $sformatf("random%0d", i));
      idle_cycles($urandom_range(1, 10), sd, sb, sdn);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1);
  end

endmodule
